uart_rx_deser: RTL and testbench

- UART receive deserializer; the stage directly upstream of the RX FIFO.
- Synchronizes the serial rx line, detects and validates the start bit, and samples the data, parity and stop bits at mid-bit using 16x oversample ticks from the baud generator.
- On frame completion it presents a zero-extended 32-bit word plus parity/frame error flags, and issues a one-cycle write pulse into the FIFO write port.

---
 rtl/uart_rx_deser.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// ---------------------------------------------------------------------------
// uart_rx_deser
//
// UART receive deserializer. This is the stage just before the RX FIFO.
// The serial line passes through a two-flop synchronizer. The block finds the
// start bit and confirms it at mid-bit. It then samples the data, optional
// parity and stop bits at mid-bit using the 16x (OVERSAMPLE) ticks from the
// baud generator. When a frame completes it presents a zero-extended word
// with parity/framing flags and pulses fifo_wr for one clock.
//
// Optional feature (compile-time macro UART_RX_OVERRUN_EN):
//   Adds overrun/overrun_clr. When the FIFO is full at frame completion, the
//   write is suppressed, the outputs keep their old values and overrun is
//   set. overrun stays set until overrun_clr is pulsed.
//   Without the macro, fifo_full is ignored and every frame is written.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..8), LSB first
//   OVERSAMPLE  baud_tick pulses per bit period (even, >= 8)
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   baud_tick    one-clk pulse, OVERSAMPLE per bit period
//   rx           raw serial input, idle high
//   parity_en    parity bit present after the data bits
//   parity_odd   1 = odd parity, 0 = even parity
//   two_stop     two stop bits expected
//   fifo_full    FIFO full flag
//   overrun_clr  (macro only) clears the sticky overrun flag
//   overrun      (macro only) sticky flag: a frame was dropped because the FIFO was full
//   Data_out     received word, bits [DATA_BITS-1:0] valid, upper bits 0
//   parity_err   parity mismatch for the word in Data_out
//   frame_err    a stop bit was sampled low for the word in Data_out
//   fifo_wr      one-clk FIFO write strobe
//   busy         high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_deser #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        baud_tick,
  input  logic        rx,
  input  logic        parity_en,
  input  logic        parity_odd,
  input  logic        two_stop,
  input  logic        fifo_full,
`ifdef UART_RX_OVERRUN_EN
  input  logic        overrun_clr,
  output logic        overrun,
`endif
  output logic [31:0] Data_out,
  output logic        parity_err,
  output logic        frame_err,
  output logic        fifo_wr,
  output logic        busy
);

  localparam int TW = $clog2(OVERSAMPLE);

  // Tick count at which the start bit is re-checked (its middle), and the
  // count at which every later bit is sampled. Each later sample point is a
  // whole bit period after the previous one, so it also falls at mid-bit.
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    BRKWAIT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [1:0]           r_sync;
  logic [TW-1:0]        r_tick;
  logic [2:0]           r_bitIdx;
  logic [DATA_BITS-1:0] r_shift;

  logic r_parEn;
  logic r_parOdd;
  logic r_twoStop;
  logic r_perr;
  logic r_ferr1;
  logic r_stopSecond;
  logic r_ferr;

  logic [31:0] r_data;
  logic        r_parityErr;
  logic        r_frameErr;
  logic        r_fifoWr;

  logic w_rxS;
  logic w_frameStart;
  logic w_startOk;
  logic w_tickClr;
  logic w_tickInc;
  logic w_sampleData;
  logic w_sampleParity;
  logic w_firstStop;
  logic w_finalStop;
  logic w_ferrNow;
  logic w_accept;

  assign w_rxS = r_sync[1];

  // Two-flop synchronizer for the asynchronous rx line. It resets to the idle
  // (high) level so that leaving reset is not seen as a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and per-clock datapath strobes. Sampling happens only on
  // a baud_tick whose tick count is at the sample point; other ticks just
  // advance the count.
  always_comb begin
    w_nextState    = r_state;
    w_frameStart   = 1'b0;
    w_startOk      = 1'b0;
    w_tickClr      = 1'b0;
    w_tickInc      = 1'b0;
    w_sampleData   = 1'b0;
    w_sampleParity = 1'b0;
    w_firstStop    = 1'b0;
    w_finalStop    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxS) begin
          w_frameStart = 1'b1;
          w_tickClr    = 1'b1;
          w_nextState  = START;
        end
      end
      START: begin
        if (baud_tick) begin
          if (r_tick == HALF_LAST) begin
            w_tickClr = 1'b1;
            if (!w_rxS) begin
              w_startOk   = 1'b1;
              w_nextState = DATA;
            end else begin
              w_nextState = IDLE;
            end
          end else begin
            w_tickInc = 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (r_tick == FULL_LAST) begin
            w_tickClr    = 1'b1;
            w_sampleData = 1'b1;
            if (r_bitIdx == LAST_BIT) begin
              w_nextState = r_parEn ? PARITY : STOP;
            end
          end else begin
            w_tickInc = 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          if (r_tick == FULL_LAST) begin
            w_tickClr      = 1'b1;
            w_sampleParity = 1'b1;
            w_nextState    = STOP;
          end else begin
            w_tickInc = 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (r_tick == FULL_LAST) begin
            w_tickClr = 1'b1;
            if (r_twoStop && !r_stopSecond) begin
              w_firstStop = 1'b1;
            end else begin
              w_finalStop = 1'b1;
              w_nextState = DONE;
            end
          end else begin
            w_tickInc = 1'b1;
          end
        end
      end
      DONE: begin
        w_nextState = r_ferr ? BRKWAIT : IDLE;
      end
      BRKWAIT: begin
        if (w_rxS) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Oversample tick counter and data bit index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick   <= '0;
      r_bitIdx <= '0;
    end else begin
      if (w_tickClr) begin
        r_tick <= '0;
      end else if (w_tickInc) begin
        r_tick <= r_tick + TW'(1);
      end
      if (w_startOk) begin
        r_bitIdx <= '0;
      end else if (w_sampleData) begin
        r_bitIdx <= r_bitIdx + 3'd1;
      end
    end
  end

  // Shift register, frame configuration and per-frame error accumulation.
  // The configuration is latched when the frame starts, so changing the
  // inputs mid-frame cannot change how the frame is decoded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift      <= '0;
      r_parEn      <= 1'b0;
      r_parOdd     <= 1'b0;
      r_twoStop    <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr1      <= 1'b0;
      r_stopSecond <= 1'b0;
      r_ferr       <= 1'b0;
    end else begin
      if (w_frameStart) begin
        r_parEn      <= parity_en;
        r_parOdd     <= parity_odd;
        r_twoStop    <= two_stop;
        r_perr       <= 1'b0;
        r_ferr1      <= 1'b0;
        r_stopSecond <= 1'b0;
      end
      if (w_sampleData) begin
        for (int i = 0; i < DATA_BITS; i++) begin
          if (r_bitIdx == 3'(i)) begin
            r_shift[i] <= w_rxS;
          end
        end
      end
      if (w_sampleParity) begin
        r_perr <= (^r_shift) ^ w_rxS ^ r_parOdd;
      end
      if (w_firstStop) begin
        r_ferr1      <= ~w_rxS;
        r_stopSecond <= 1'b1;
      end
      if (w_finalStop) begin
        r_ferr <= w_ferrNow;
      end
    end
  end

  // The error flag covers both stop samples. r_ferr1 is cleared at frame start,
  // so it contributes nothing when only one stop bit is used.
  assign w_ferrNow = r_ferr1 | ~w_rxS;

`ifdef UART_RX_OVERRUN_EN
  assign w_accept = ~fifo_full;

  // Sticky overrun flag. Setting takes priority over clearing so that a drop
  // coinciding with a clear is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (w_finalStop && fifo_full) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end
`else
  logic w_unusedFull;
  assign w_accept     = 1'b1;
  assign w_unusedFull = fifo_full;
`endif

  // Output registers are loaded on the same edge that enters DONE. fifo_wr and
  // the new word are therefore visible during the DONE clock, one clock after
  // the tick that sampled the last stop bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data      <= '0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_fifoWr    <= 1'b0;
    end else begin
      r_fifoWr <= w_finalStop & w_accept;
      if (w_finalStop && w_accept) begin
        r_data      <= 32'(r_shift);
        r_parityErr <= r_perr;
        r_frameErr  <= w_ferrNow;
      end
    end
  end

  assign Data_out   = r_data;
  assign parity_err = r_parityErr;
  assign frame_err  = r_frameErr;
  assign fifo_wr    = r_fifoWr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deser
//
// Testbench for uart_rx_deser (DATA_BITS=8, OVERSAMPLE=16).
// baud_tick fires every 4 clocks, so one bit period is 64 clocks.
// Each frame that should produce a FIFO write pushes its expected word and
// flags into a queue. A separate monitor compares on every fifo_wr it sees.
// Define UART_RX_OVERRUN_EN to also exercise the overrun ports.
// ---------------------------------------------------------------------------
module tb_uart_rx_deser;

  localparam int BIT_CLK = 64;

  typedef struct {
    logic [31:0] data;
    logic        perr;
    logic        ferr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        baud_tick;
  logic        rx;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        fifo_full;
  logic [31:0] Data_out;
  logic        parity_err;
  logic        frame_err;
  logic        fifo_wr;
  logic        busy;
`ifdef UART_RX_OVERRUN_EN
  logic        overrun;
  logic        overrun_clr;
`endif

  exp_t expQ[$];
  int   nChecks = 0;
  int   nErrors = 0;
  logic prevWr  = 1'b0;

  uart_rx_deser #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .fifo_full  (fifo_full),
`ifdef UART_RX_OVERRUN_EN
    .overrun_clr(overrun_clr),
    .overrun    (overrun),
`endif
    .Data_out   (Data_out),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .fifo_wr    (fifo_wr),
    .busy       (busy)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick generator: a one-clock pulse every fourth clock.
  initial begin
    int tickCnt;
    tickCnt   = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tickCnt   = (tickCnt + 1) % 4;
      baud_tick = (tickCnt == 0);
    end
  end

  // Watchdog: the stimulus has a fixed length, so overrunning this bound means something hung.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", nErrors, nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expectWrite(input logic [31:0] data, input logic perr, input logic ferr);
    exp_t e;
    e.data = data;
    e.perr = perr;
    e.ferr = ferr;
    expQ.push_back(e);
  endtask

  task automatic driveBit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idleBits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLK) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] data, input bit usePar, input logic parBit,
                           input logic stop1, input bit useStop2, input logic stop2);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    if (usePar) driveBit(parBit);
    driveBit(stop1);
    if (useStop2) driveBit(stop2);
  endtask

  // Send a frame, record the expected write and return the line to idle.
  task automatic applyStimulus(input logic [7:0] data, input bit usePar, input logic parBit,
                               input logic stop1, input bit useStop2, input logic stop2,
                               input logic expPerr, input logic expFerr);
    expectWrite({24'h0, data}, expPerr, expFerr);
    sendFrame(data, usePar, parBit, stop1, useStop2, stop2);
    idleBits(2);
  endtask

  // Monitor: each fifo_wr must match the oldest expectation, and must last only one clock.
  always @(negedge clk) begin
    if (fifo_wr === 1'b1) begin
      if (prevWr === 1'b1) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL fifoWrWidth: fifo_wr high for more than 1 clk at %0t", $time);
      end else if (expQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL unexpectedWrite: fifo_wr with Data_out=0x%08h, none expected at %0t",
                 Data_out, $time);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("Data_out", Data_out, e.data);
        checkOutput("parity_err", {31'h0, parity_err}, {31'h0, e.perr});
        checkOutput("frame_err", {31'h0, frame_err}, {31'h0, e.ferr});
      end
    end
    prevWr = fifo_wr;
  end

  initial begin
    reset      = 1'b0;
    rx         = 1'b1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    fifo_full  = 1'b0;
`ifdef UART_RX_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    repeat (5) @(negedge clk);
    checkOutput("rstData", Data_out, 32'h0);
    checkOutput("rstParity", {31'h0, parity_err}, 32'h0);
    checkOutput("rstFrame", {31'h0, frame_err}, 32'h0);
    checkOutput("rstWr", {31'h0, fifo_wr}, 32'h0);
    checkOutput("rstBusy", {31'h0, busy}, 32'h0);
`ifdef UART_RX_OVERRUN_EN
    checkOutput("rstOverrun", {31'h0, overrun}, 32'h0);
`endif
    reset = 1'b1;
    idleBits(1);

    // Plain 8N1 frame.
    applyStimulus(8'hA5, 0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("busyAfterA5", {31'h0, busy}, 32'h0);

    // Even parity: 0x3C has four ones, so parity bit 1 is wrong and 0 is right.
    parity_en = 1'b1;
    applyStimulus(8'h3C, 1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h3C, 1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    // Odd parity: parity bit 0 on 0x3C is wrong, and bit 1 on 0x38 (three ones) is also wrong.
    parity_odd = 1'b1;
    applyStimulus(8'h3C, 1, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h38, 1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    // Framing error with the line held low afterwards: one write, then nothing until idle.
    expectWrite(32'h55, 1'b0, 1'b1);
    sendFrame(8'h55, 0, 1'b0, 1'b0, 0, 1'b1);
    rx = 1'b0;
    repeat (BIT_CLK + BIT_CLK / 2) @(negedge clk);
    checkOutput("busyInBreak", {31'h0, busy}, 32'h1);
    repeat (BIT_CLK + BIT_CLK / 2) @(negedge clk);
    idleBits(2);
    applyStimulus(8'h12, 0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0);

    // Two stop bits: a low first stop bit is still a framing error.
    two_stop = 1'b1;
    applyStimulus(8'hC3, 0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h3E, 0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    two_stop = 1'b0;

    // 5-tick glitch is rejected at mid start bit.
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idleBits(2);
    checkOutput("busyAfterGlitch", {31'h0, busy}, 32'h0);
    applyStimulus(8'h7E, 0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of data bit 4 of 0xFF.
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b1);
    rx = 1'b1;
    repeat (BIT_CLK / 2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midRstData", Data_out, 32'h0);
    checkOutput("midRstWr", {31'h0, fifo_wr}, 32'h0);
    checkOutput("midRstBusy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idleBits(4);
    applyStimulus(8'h81, 0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0);

    // FIFO full at frame completion.
    fifo_full = 1'b1;
`ifdef UART_RX_OVERRUN_EN
    sendFrame(8'h99, 0, 1'b0, 1'b1, 0, 1'b1);
    idleBits(2);
    checkOutput("overrunSet", {31'h0, overrun}, 32'h1);
    checkOutput("overrunDataHeld", Data_out, 32'h81);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    checkOutput("overrunClr", {31'h0, overrun}, 32'h0);
`else
    applyStimulus(8'h99, 0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
`endif
    fifo_full = 1'b0;

    idleBits(1);
    checkOutput("pendingWrites", expQ.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
